// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control unit.
// The HALT state exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // ALUop encodings shared with the ALU control block
  localparam logic [2:0] ALU_SUB   = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SLT   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_ADDU  = 3'b101;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctrl_t;

  function automatic logic [2:0] i_type_alu_op(input logic [5:0] op);
    case (op)
      OP_ADDI:  return ALU_ADD;
      OP_ADDIU: return ALU_ADDU;
      OP_SLTI:  return ALU_SLT;
      OP_ANDI:  return ALU_AND;
      OP_ORI:   return ALU_OR;
      default:  return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Moore output decode: state plus latched opcode to raw control lines
// (before mem_ready and reset gating). CTRL_ILLEGAL_TRAP_EN adds illegal_op.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  output ctrl_t      ctrl
`ifdef CTRL_ILLEGAL_TRAP_EN
  , output logic     illegal_op
`endif
);

  // per-state control word; anything not set stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = i_type_alu_op(op);
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = (state == S_HALT);
`endif

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: state register, next-state, opcode latch
// and mem_ready/reset gating. CTRL_ILLEGAL_TRAP_EN enables the HALT trap.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUop
`ifdef CTRL_ILLEGAL_TRAP_EN
  , output logic     illegal_op
`endif
);

  state_t     state_r;
  state_t     next_state_s;
  logic [5:0] op_r;
  ctrl_t      dec_s;
  logic       fetch_ok_s;

  // state register and opcode latch captured during DECODE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FETCH;
      op_r    <= 6'b000000;
    end else begin
      state_r <= next_state_s;
      if (state_r == S_DECODE) op_r <= opcode;
    end
  end

  // next-state logic; memory states wait on mem_ready
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH:     next_state_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state_s = S_MEM_ADDR;
          OP_R:         next_state_s = S_R_EXEC;
          OP_BEQ:       next_state_s = S_BRANCH;
          OP_J:         next_state_s = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI:
                        next_state_s = S_I_EXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:      next_state_s = S_HALT;
`else
          default:      next_state_s = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR:  next_state_s = (op_r == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  next_state_s = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    next_state_s = S_FETCH;
      S_MEM_WRITE: next_state_s = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    next_state_s = S_R_WB;
      S_R_WB:      next_state_s = S_FETCH;
      S_I_EXEC:    next_state_s = S_I_WB;
      S_I_WB:      next_state_s = S_FETCH;
      S_BRANCH:    next_state_s = S_FETCH;
      S_JUMP:      next_state_s = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT:      next_state_s = S_HALT;
`endif
      default:     next_state_s = S_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state      (state_r),
    .op         (op_r),
    .ctrl       (dec_s)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .illegal_op (illegal_op)
`endif
  );

  // IR/PC load in FETCH only on the cycle the read completes
  assign fetch_ok_s = (state_r != S_FETCH) || mem_ready;

  // reset masks every write enable and the read request combinationally
  assign PCWrite     = dec_s.pc_write & fetch_ok_s & ~rst;
  assign IRWrite     = dec_s.ir_write & fetch_ok_s & ~rst;
  assign PCWriteCond = dec_s.pc_write_cond & ~rst;
  assign RegWrite    = dec_s.reg_write & ~rst;
  assign MemWrite    = dec_s.mem_write & ~rst;
  assign MemRead     = dec_s.mem_read & ~rst;
  assign IorD        = dec_s.ior_d;
  assign MemtoReg    = dec_s.mem_to_reg;
  assign RegDst      = dec_s.reg_dst;
  assign ALUSrcA     = dec_s.alu_src_a;
  assign ALUSrcB     = dec_s.alu_src_b;
  assign PCSource    = dec_s.pc_source;
  assign ALUop       = dec_s.alu_op;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle MIPS main control unit. Sequences each instruction through fetch/decode/execute/memory/writeback states and drives every datapath control line. That includes the 3-bit `ALUop` consumed by the ALU control block, which maps `ALUop`/`funct` to `ALUctrl`. This block is the producer side of the `ALUop` interface and sits between the instruction register and the datapath muxes/enables.

## Interface
Parameters:
- none (all encodings are fixed in the shared package)

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; sampled in DECODE.
- `mem_ready`  in  1  memory handshake; 1 = current read/write completes this cycle.
- `PCWrite`  out  1  unconditional PC load.
- `PCWriteCond`  out  1  PC load if datapath zero flag = 1.
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `MemRead`  out  1  memory read request.
- `MemWrite`  out  1  memory write request.
- `IRWrite`  out  1  instruction register load.
- `MemtoReg`  out  1  register write data: 0 = ALUOut, 1 = MDR.
- `RegDst`  out  1  destination register: 0 = rt, 1 = rd.
- `RegWrite`  out  1  register file write.
- `ALUSrcA`  out  1  ALU A input: 0 = PC, 1 = A.
- `ALUSrcB`  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- `PCSource`  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `ALUop`  out  3  000 SUB, 001 ADD, 010 SLT, 011 AND, 100 OR, 101 ADDU, 111 R-type (funct decides).
- `illegal_op`  out  1  present only with `CTRL_ILLEGAL_TRAP_EN`.

## Operation
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000, ADDIU 001001, SLTI 001010, ANDI 001100, ORI 001101.
- Moore FSM. Outputs decode purely from the state register, except these, which are ANDed with `mem_ready`:
  - `IRWrite` and `PCWrite` in FETCH.
  - MEM_READ and MEM_WRITE advance only when `mem_ready` = 1.
- States and actions (unlisted outputs = 0):
  - FETCH: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=ADD, PCSource=00, IRWrite & PCWrite when ready. Goes to DECODE when ready, else stays.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=ADD (branch target). Next state by opcode:
    - LW/SW → MEM_ADDR
    - R → R_EXEC
    - BEQ → BRANCH
    - J → JUMP
    - ADDI/ADDIU/SLTI/ANDI/ORI → I_EXEC
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUop=ADD. Goes to MEM_READ (LW) or MEM_WRITE (SW).
  - MEM_READ: MemRead, IorD=1. Goes to MEM_WB when ready.
  - MEM_WB: RegWrite, MemtoReg=1, RegDst=0. Goes to FETCH.
  - MEM_WRITE: MemWrite, IorD=1. Goes to FETCH when ready.
  - R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=111. Goes to R_WB.
  - R_WB: RegWrite, RegDst=1, MemtoReg=0. Goes to FETCH.
  - I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUop by opcode:
    - ADDI → ADD
    - ADDIU → ADDU
    - SLTI → SLT
    - ANDI → AND
    - ORI → OR
    - Goes to I_WB.
  - I_WB: RegWrite, RegDst=0, MemtoReg=0. Goes to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=SUB, PCWriteCond, PCSource=01. Goes to FETCH.
  - JUMP: PCWrite, PCSource=10. Goes to FETCH.
- The opcode used by I_EXEC and MEM_ADDR is latched into an internal 6-bit register in DECODE. Later IR changes are ignored.

## Timing
- Instruction latency with zero wait states, counted from FETCH entry to the next FETCH:
  - LW: 5 cycles
  - SW, R, I-type: 4 cycles
  - BEQ, J: 3 cycles
- Each cycle with `mem_ready` = 0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. During the wait, `MemRead`/`MemWrite`, `IorD` and the ALU selects are held constant.
- Reset:
  - `rst` = 1 forces the state to FETCH immediately, asynchronously.
  - While `rst` = 1, all write enables are forced to 0: `PCWrite`, `PCWriteCond`, `IRWrite`, `RegWrite`, `MemWrite`.
  - `MemRead` = 0 during reset; the other outputs take their FETCH values.
  - The first fetch begins on the first rising edge after `rst` deasserts.
  - Reset mid-instruction abandons it with no partial register or memory write.
- `mem_ready` asserted outside FETCH, MEM_READ and MEM_WRITE is ignored.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An unlisted opcode in DECODE enters the HALT state.
  - In HALT, all enables are 0 and `illegal_op` = 1.
  - HALT is sticky until `rst`.
  - `illegal_op` resets to 0.
- Not defined:
  - The `illegal_op` port and HALT state are absent.
  - An unlisted opcode goes DECODE → FETCH as a NOP (2 cycles, no writes).

## Structure
- Shared package `mips_ctrl_pkg`:
  - opcode constants
  - `ALUop` encodings (must match the ALU control block)
  - state enum
  - `ALUSrcB`/`PCSource` select constants
- One sub-module, `mips_ctrl_outdec`: combinational state + latched opcode → control outputs. The top level holds the state register, next-state logic, opcode latch and `mem_ready` gating.

## Test plan
- Reset, then R-type (opcode 000000), `mem_ready` = 1 → states FETCH, DECODE, R_EXEC, R_WB. `ALUop` = 111 in R_EXEC; `RegWrite` = 1 and `RegDst` = 1 only in cycle 4.
- LW (100011) with `mem_ready` low 2 cycles in MEM_READ → 7 cycles total. `MemRead` = 1 and `IorD` = 1 held during the wait; `MemtoReg` = 1 and `RegWrite` pulse once.
- SLTI (001010) → `ALUop` = 010 in I_EXEC. ORI (001101) → `ALUop` = 100. BEQ (000100) → `ALUop` = 000, `PCWriteCond` = 1, `PCSource` = 01, 3 cycles.
- FETCH with `mem_ready` = 0 for 3 cycles → no `IRWrite`/`PCWrite` pulse until the ready cycle, then exactly one.
- `rst` asserted in MEM_WRITE mid-SW → immediate FETCH state, `MemWrite` = 0 in the same cycle, no write on the next edge.
- Opcode 111111: with `CTRL_ILLEGAL_TRAP_EN`, `illegal_op` = 1 and it stays halted for 10 cycles. Without the macro, FETCH is re-entered 2 cycles after fetch.
